// File: rtl/wb_write_arbiter.sv
// Write-back port arbiter: the pipeline always wins the slot, auxiliary results
// queue in order and drain into idle slots; flags reads of still-pending writes.
module wb_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_en,
  input  logic [3:0]  pipe_dest,
  input  logic [31:0] pipe_result,
  input  logic        aux_valid,
  input  logic [3:0]  aux_dest,
  input  logic [31:0] aux_result,
  output logic        aux_ready,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  output logic        hazard,
  output logic        write_back_en,
  output logic [3:0]  dest_wb,
  output logic [31:0] result_wb,
  output logic [2:0]  q_count
);

  // Storage is sized for the largest legal DEPTH; only the first DEPTH slots are used.
  localparam int SLOTS = 4;

  logic [3:0]  q_dest  [SLOTS];
  logic [31:0] q_data  [SLOTS];
  logic [3:0]  nq_dest [SLOTS];
  logic [31:0] nq_data [SLOTS];
  logic [2:0]  nq_count;
  logic        n_wb_en;
  logic [3:0]  n_dest;
  logic [31:0] n_result;
  logic        accept;
  logic        pop;
  logic        bypass;
  logic        push;
  logic [2:0]  cnt;

  assign aux_ready = (q_count != 3'(DEPTH));
  assign accept    = aux_valid && aux_ready;
  assign pop       = !pipe_wb_en && (q_count != 3'd0);

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      nq_dest[i] = q_dest[i];
      nq_data[i] = q_data[i];
    end
    n_wb_en  = 1'b0;
    n_dest   = dest_wb;
    n_result = result_wb;
    bypass   = 1'b0;
    cnt      = 3'd0;

    // Rebuild the queue front-to-back, dropping the popped head and any
    // entry overwritten by this cycle's pipeline write; order is preserved.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(q_count) &&
          !(pipe_wb_en && q_dest[i[1:0]] == pipe_dest) &&
          !(pop && i == 0)) begin
        nq_dest[cnt[1:0]] = q_dest[i[1:0]];
        nq_data[cnt[1:0]] = q_data[i[1:0]];
        cnt = cnt + 3'd1;
      end
    end

    if (pipe_wb_en) begin
      n_wb_en  = 1'b1;
      n_dest   = pipe_dest;
      n_result = pipe_result;
    end else if (pop) begin
      n_wb_en  = 1'b1;
      n_dest   = q_dest[0];
      n_result = q_data[0];
    end else if (accept) begin
      n_wb_en  = 1'b1;
      n_dest   = aux_dest;
      n_result = aux_result;
      bypass   = 1'b1;
    end

    push = accept && !bypass && !(pipe_wb_en && aux_dest == pipe_dest);
    if (push) begin
      nq_dest[cnt[1:0]] = aux_dest;
      nq_data[cnt[1:0]] = aux_result;
      cnt = cnt + 3'd1;
    end
    nq_count = cnt;
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(q_count) && (q_dest[i[1:0]] == src1 || q_dest[i[1:0]] == src2))
        hazard = 1'b1;
    end
    if (write_back_en && (dest_wb == src1 || dest_wb == src2))
      hazard = 1'b1;
    if (accept && (aux_dest == src1 || aux_dest == src2))
      hazard = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_back_en <= 1'b0;
      dest_wb       <= 4'd0;
      result_wb     <= 32'd0;
      q_count       <= 3'd0;
      for (int i = 0; i < SLOTS; i++) begin
        q_dest[i] <= 4'd0;
        q_data[i] <= 32'd0;
      end
    end else begin
      write_back_en <= n_wb_en;
      dest_wb       <= n_dest;
      result_wb     <= n_result;
      q_count       <= nq_count;
      for (int i = 0; i < SLOTS; i++) begin
        q_dest[i] <= nq_dest[i];
        q_data[i] <= nq_data[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based
// reference model of the write-back slot rules.
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [3:0]  pipe_dest;
  logic [31:0] pipe_result;
  logic        aux_valid;
  logic [3:0]  aux_dest;
  logic [31:0] aux_result;
  logic        aux_ready;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        hazard;
  logic        write_back_en;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic [2:0]  q_count;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_dest(pipe_dest), .pipe_result(pipe_result),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_result(aux_result),
    .aux_ready(aux_ready), .src1(src1), .src2(src2), .hazard(hazard),
    .write_back_en(write_back_en), .dest_wb(dest_wb), .result_wb(result_wb),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic        m_en   = 1'b0;
  logic [3:0]  m_dest = 4'd0;
  logic [31:0] m_res  = 32'd0;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check registers.
  task automatic cycle(input logic r, input logic p_en, input logic [3:0] pd, input logic [31:0] pr,
                       input logic a_v, input logic [3:0] ad, input logic [31:0] ar,
                       input logic [3:0] s1, input logic [3:0] s2, output logic acc);
    logic exp_hz;
    ent_t keep[$];
    ent_t e;
    @(negedge clk);
    rst = r; pipe_wb_en = p_en; pipe_dest = pd; pipe_result = pr;
    aux_valid = a_v; aux_dest = ad; aux_result = ar; src1 = s1; src2 = s2;
    #1;
    acc = a_v && (mq.size() != DEPTH);
    exp_hz = 1'b0;
    foreach (mq[i]) if (mq[i].d == s1 || mq[i].d == s2) exp_hz = 1'b1;
    if (m_en && (m_dest == s1 || m_dest == s2)) exp_hz = 1'b1;
    if (acc && (ad == s1 || ad == s2)) exp_hz = 1'b1;
    check_val("aux_ready", 32'(aux_ready), 32'(mq.size() != DEPTH));
    check_val("hazard", 32'(hazard), 32'(exp_hz));

    if (r) begin
      mq.delete();
      m_en = 1'b0; m_dest = 4'd0; m_res = 32'd0;
    end else if (p_en) begin
      m_en = 1'b1; m_dest = pd; m_res = pr;
      foreach (mq[i]) if (mq[i].d != pd) keep.push_back(mq[i]);
      mq = keep;
      if (acc && ad != pd) begin e.d = ad; e.v = ar; mq.push_back(e); end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_en = 1'b1; m_dest = e.d; m_res = e.v;
      if (acc) begin e.d = ad; e.v = ar; mq.push_back(e); end
    end else if (acc) begin
      m_en = 1'b1; m_dest = ad; m_res = ar;
    end else begin
      m_en = 1'b0;
    end

    @(posedge clk);
    #1;
    check_val("write_back_en", 32'(write_back_en), 32'(m_en));
    check_val("dest_wb", 32'(dest_wb), 32'(m_dest));
    check_val("result_wb", result_wb, m_res);
    check_val("q_count", 32'(q_count), 32'(mq.size()));
  endtask

  task automatic idle(input logic [3:0] s1, input logic [3:0] s2);
    logic acc;
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, s1, s2, acc);
  endtask

  initial begin
    logic        acc;
    logic        hv;
    logic [3:0]  hd;
    logic [31:0] hr;
    logic        r, p;
    logic [3:0]  pd, s1, s2;
    logic [31:0] pr;

    rst = 1'b1; pipe_wb_en = 1'b0; pipe_dest = 4'd0; pipe_result = 32'd0;
    aux_valid = 1'b0; aux_dest = 4'd0; aux_result = 32'd0; src1 = 4'd0; src2 = 4'd0;

    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, acc);
    check_val("rst_wb_en", 32'(write_back_en), 32'd0);
    check_val("rst_result", result_wb, 32'd0);
    check_val("rst_ready", 32'(aux_ready), 32'd1);
    idle(4'd3, 4'd5);
    check_val("rst_hazard", 32'(hazard), 32'd0);

    // bypass into an idle slot
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hDEADBEEF, 4'd0, 4'd0, acc);
    check_val("byp_dest", 32'(dest_wb), 32'd4);
    check_val("byp_data", result_wb, 32'hDEADBEEF);
    idle(4'd0, 4'd0);

    // pipeline priority fills the queue
    cycle(1'b0, 1'b1, 4'd1, 32'h100, 1'b1, 4'd6, 32'h11, 4'd0, 4'd0, acc);
    cycle(1'b0, 1'b1, 4'd1, 32'h101, 1'b1, 4'd7, 32'h22, 4'd0, 4'd0, acc);
    check_val("prio_qcount", 32'(q_count), 32'd2);
    check_val("prio_ready", 32'(aux_ready), 32'd0);
    cycle(1'b0, 1'b1, 4'd1, 32'h102, 1'b1, 4'd8, 32'h33, 4'd0, 4'd7, acc);
    check_val("prio_hazard", 32'(hazard), 32'd1);
    idle(4'd0, 4'd7);
    check_val("drain_first", 32'(dest_wb), 32'd6);
    idle(4'd0, 4'd0);
    check_val("drain_second", 32'(dest_wb), 32'd7);
    idle(4'd0, 4'd0);

    // WAW squash of a queued entry
    cycle(1'b0, 1'b1, 4'd2, 32'h1, 1'b1, 4'd9, 32'hAAAA, 4'd0, 4'd0, acc);
    cycle(1'b0, 1'b1, 4'd9, 32'h5555, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, acc);
    check_val("waw_qcount", 32'(q_count), 32'd0);
    check_val("waw_data", result_wb, 32'h5555);
    idle(4'd9, 4'd0);
    check_val("waw_no_stale", 32'(write_back_en), 32'd0);

    // simultaneous push and pop
    cycle(1'b0, 1'b1, 4'd3, 32'h3, 1'b1, 4'd10, 32'hB0, 4'd0, 4'd0, acc);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd11, 32'hB1, 4'd0, 4'd0, acc);
    check_val("pp_dest", 32'(dest_wb), 32'd10);
    check_val("pp_qcount", 32'(q_count), 32'd1);
    idle(4'd0, 4'd0);
    check_val("pp_order", 32'(dest_wb), 32'd11);

    // reset while the queue is full
    cycle(1'b0, 1'b1, 4'd1, 32'h7, 1'b1, 4'd12, 32'hC0, 4'd0, 4'd0, acc);
    cycle(1'b0, 1'b1, 4'd1, 32'h8, 1'b1, 4'd13, 32'hC1, 4'd0, 4'd0, acc);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, acc);
    check_val("rstmid_wb_en", 32'(write_back_en), 32'd0);
    check_val("rstmid_qcount", 32'(q_count), 32'd0);
    idle(4'd12, 4'd13);
    idle(4'd12, 4'd13);

    // randomized traffic with a producer that holds rejected offers
    hv = 1'b0; hd = 4'd0; hr = 32'd0;
    for (int n = 0; n < 800; n++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 99) < 60);
        hd = 4'($urandom_range(0, 7));
        hr = $urandom;
      end
      r  = ($urandom_range(0, 99) == 0);
      p  = ($urandom_range(0, 99) < 45);
      pd = 4'($urandom_range(0, 7));
      pr = $urandom;
      s1 = 4'($urandom_range(0, 15));
      s2 = 4'($urandom_range(0, 15));
      cycle(r, p, pd, pr, hv, hd, hr, s1, s2, acc);
      if (acc) hv = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
